// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and byte-SRAM beat signals of the load/store sequencer.
interface mem_access_unit_if #(parameter int ADDR_W = 5);
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [31:0]       Addr_i;
  logic [31:0]       WriteData_i;
  logic [31:0]       ReadData_o;
  logic              Stall_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;
  modport master (
    input  MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_rdata_i,
    output ReadData_o, Stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport slave (
    output MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_rdata_i,
    input  ReadData_o, Stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: splits pipeline word loads/stores into four little-endian byte beats on a byte-wide SRAM.
module mem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, BEAT, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d, rdata_q, rdata_d;
  logic [23:0]       asm_q, asm_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic              req;
  logic              unused;
  assign req    = bus.MemRead_i | bus.MemWrite_i;
  assign unused = ^bus.Addr_i[31:ADDR_W];
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = BEAT;
        beat_d  = 2'd0;
        addr_d  = bus.Addr_i[ADDR_W-1:0];
        data_d  = bus.WriteData_i;
        wr_d    = bus.MemWrite_i;
        rd_d    = bus.MemRead_i;
      end
      BEAT: begin
        beat_d = beat_q + 2'd1;
        // read data trails its beat by one cycle, so beat k lands byte k-1
        if (!wr_q && beat_q != 2'd0) asm_d[{beat_q - 2'd1, 3'b000} +: 8] = bus.mem_rdata_i;
        if (beat_q == 2'd3) begin
          state_d = wr_q ? DONE : DRAIN;
          if (wr_q && rd_q) rdata_d = data_q;
        end
      end
      DRAIN: begin
        rdata_d = {bus.mem_rdata_i, asm_q};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.Stall_o     = rst_i && (state_q == IDLE ? req : state_q != DONE);
  assign bus.mem_en_o    = rst_i && state_q == BEAT;
  assign bus.mem_we_o    = bus.mem_en_o && wr_q;
  assign bus.mem_addr_o  = addr_q + ADDR_W'(beat_q);
  assign bus.mem_wdata_o = data_q[{beat_q, 3'b000} +: 8];
  assign bus.ReadData_o  = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven load/store vectors with a beat scoreboard against a 1-cycle-latency byte SRAM.
module tb_mem_access_unit;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_stall;
  } vec_t;
  typedef struct {
    logic [4:0] a;
    logic       we;
    logic [7:0] d;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] mem [32];
  logic [7:0] sram_rd = 8'h00;
  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  mem_access_unit_if #(.ADDR_W(5)) bus();
  mem_access_unit #(.ADDR_W(5)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata_i = sram_rd;
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      else sram_rd <= mem[bus.mem_addr_o];
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_en_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL beat_unexpected: got beat addr %h we %b, expected none", bus.mem_addr_o, bus.mem_we_o);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_addr", 32'(bus.mem_addr_o), 32'(b.a));
        chk("beat_we", 32'(bus.mem_we_o), 32'(b.we));
        if (b.we) chk("beat_wdata", 32'(bus.mem_wdata_o), 32'(b.d));
      end
    end
  end
  task automatic push_beats(input vec_t v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{a: 5'(v.addr + 32'(k)), we: v.wr, d: v.wdata[8*k +: 8]});
  endtask
  task automatic access(input vec_t v, input bit keep);
    int n;
    @(negedge clk);
    chk("idle_en", 32'(bus.mem_en_o), 32'd0);
    bus.MemRead_i   = v.rd;
    bus.MemWrite_i  = v.wr;
    bus.Addr_i      = v.addr;
    bus.WriteData_i = v.wdata;
    push_beats(v, 4);
    #1;
    n = 0;
    while (bus.Stall_o && n < 20) begin
      n++;
      if (n == 2) begin
        bus.Addr_i      = v.addr ^ 32'h15;
        bus.WriteData_i = ~v.wdata;
      end
      @(negedge clk);
    end
    chk("stall_cycles", 32'(n), 32'(v.exp_stall));
    chk("read_data", bus.ReadData_o, v.exp_rdata);
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    if (!keep) begin
      bus.MemRead_i  = 1'b0;
      bus.MemWrite_i = 1'b0;
    end
  endtask
  vec_t tbl[7];
  initial begin
    vec_t v;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    tbl[0] = '{rd: 0, wr: 1, addr: 8,  wdata: 32'hA1B2C3D4, exp_rdata: 32'h00000000, exp_stall: 5};
    tbl[1] = '{rd: 1, wr: 0, addr: 8,  wdata: 32'h0,        exp_rdata: 32'hA1B2C3D4, exp_stall: 6};
    tbl[2] = '{rd: 0, wr: 1, addr: 30, wdata: 32'h11223344, exp_rdata: 32'hA1B2C3D4, exp_stall: 5};
    tbl[3] = '{rd: 1, wr: 0, addr: 30, wdata: 32'h0,        exp_rdata: 32'h11223344, exp_stall: 6};
    tbl[4] = '{rd: 1, wr: 1, addr: 4,  wdata: 32'hDEADBEEF, exp_rdata: 32'hDEADBEEF, exp_stall: 5};
    tbl[5] = '{rd: 1, wr: 0, addr: 4,  wdata: 32'h0,        exp_rdata: 32'hDEADBEEF, exp_stall: 6};
    tbl[6] = '{rd: 0, wr: 1, addr: 16, wdata: 32'h55667788, exp_rdata: 32'hDEADBEEF, exp_stall: 5};
    bus.MemRead_i   = 1'b1;
    bus.MemWrite_i  = 1'b0;
    bus.Addr_i      = 32'd0;
    bus.WriteData_i = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(bus.Stall_o), 32'd0);
    chk("rst_en", 32'(bus.mem_en_o), 32'd0);
    chk("rst_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_rdata", bus.ReadData_o, 32'd0);
    bus.MemRead_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) access(tbl[i], 1'b0);
    // reset abandons a load during its third beat
    @(negedge clk);
    v = '{rd: 1, wr: 0, addr: 16, wdata: 32'h0, exp_rdata: 32'h55667788, exp_stall: 6};
    bus.MemRead_i = 1'b1;
    bus.Addr_i    = v.addr;
    push_beats(v, 3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 32'(bus.Stall_o), 32'd0);
    chk("midrst_en", 32'(bus.mem_en_o), 32'd0);
    chk("midrst_rdata", bus.ReadData_o, 32'd0);
    chk("midrst_beats_left", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    bus.MemRead_i = 1'b0;
    #1;
    chk("postrst_stall", 32'(bus.Stall_o), 32'd0);
    chk("postrst_en", 32'(bus.mem_en_o), 32'd0);
    access(v, 1'b0);
    // load then a store already waiting while the load finishes
    v = '{rd: 1, wr: 0, addr: 0, wdata: 32'h0, exp_rdata: 32'h00001122, exp_stall: 6};
    access(v, 1'b1);
    bus.MemRead_i   = 1'b0;
    bus.MemWrite_i  = 1'b1;
    bus.Addr_i      = 32'd4;
    bus.WriteData_i = 32'hCAFEF00D;
    #1;
    chk("done_stall", 32'(bus.Stall_o), 32'd0);
    chk("done_en", 32'(bus.mem_en_o), 32'd0);
    v = '{rd: 0, wr: 1, addr: 4, wdata: 32'hCAFEF00D, exp_rdata: 32'h00001122, exp_stall: 5};
    access(v, 1'b0);
    v = '{rd: 1, wr: 0, addr: 4, wdata: 32'h0, exp_rdata: 32'hCAFEF00D, exp_stall: 6};
    access(v, 1'b0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
